y86_execute_stage: RTL and testbench

- Pipelined Y86-64 execute stage. Sits directly downstream of the decode stage and consumes its E-register fields.
- Contains the ALU, the condition-code register (ZF/SF/OF) and the branch/cmov condition evaluator.
- Registers its results into the M pipeline register for the memory stage.
- Exposes combinational e_valE/e_dstE/e_Cnd for decode forwarding and fetch/PC-select misprediction handling.

---
 rtl/y86_pkg.sv | 65 ++++++
 rtl/y86_execute_stage_alu.sv | 54 +++++
 rtl/y86_execute_stage.sv | 121 ++++++++++++
 tb/tb_y86_execute_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
// Module      : y86_pkg
// Description : Shared Y86-64 encodings for the execute stage and its ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

    localparam logic [3:0] c_icode_halt   = 4'h0;
    localparam logic [3:0] c_icode_nop    = 4'h1;
    localparam logic [3:0] c_icode_rrmovq = 4'h2;
    localparam logic [3:0] c_icode_irmovq = 4'h3;
    localparam logic [3:0] c_icode_rmmovq = 4'h4;
    localparam logic [3:0] c_icode_mrmovq = 4'h5;
    localparam logic [3:0] c_icode_opq    = 4'h6;
    localparam logic [3:0] c_icode_jxx    = 4'h7;
    localparam logic [3:0] c_icode_call   = 4'h8;
    localparam logic [3:0] c_icode_ret    = 4'h9;
    localparam logic [3:0] c_icode_pushq  = 4'hA;
    localparam logic [3:0] c_icode_popq   = 4'hB;

    localparam logic [3:0] c_alu_add = 4'h0;
    localparam logic [3:0] c_alu_sub = 4'h1;
    localparam logic [3:0] c_alu_and = 4'h2;
    localparam logic [3:0] c_alu_xor = 4'h3;

    localparam logic [3:0] c_cond_yes = 4'h0;
    localparam logic [3:0] c_cond_le  = 4'h1;
    localparam logic [3:0] c_cond_l   = 4'h2;
    localparam logic [3:0] c_cond_e   = 4'h3;
    localparam logic [3:0] c_cond_ne  = 4'h4;
    localparam logic [3:0] c_cond_ge  = 4'h5;
    localparam logic [3:0] c_cond_g   = 4'h6;

    localparam logic [3:0] c_stat_aok = 4'h1;
    localparam logic [3:0] c_stat_hlt = 4'h2;
    localparam logic [3:0] c_stat_adr = 4'h3;
    localparam logic [3:0] c_stat_ins = 4'h4;

    localparam logic [3:0] c_rnone = 4'hF;

    localparam logic [3:0] c_bubble_stat  = c_stat_aok;
    localparam logic [3:0] c_bubble_icode = c_icode_nop;
    localparam logic       c_bubble_cnd   = 1'b0;

    // Condition codes are packed {ZF,SF,OF}.
    function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
        logic zf;
        logic lt;
        zf = cc[2];
        lt = cc[1] ^ cc[0];
        case (ifun)
            c_cond_yes: cond_eval = 1'b1;
            c_cond_le:  cond_eval = lt | zf;
            c_cond_l:   cond_eval = lt;
            c_cond_e:   cond_eval = zf;
            c_cond_ne:  cond_eval = ~zf;
            c_cond_ge:  cond_eval = ~lt;
            c_cond_g:   cond_eval = ~lt & ~zf;
            default:    cond_eval = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/y86_execute_stage_alu.sv
`default_nettype none
// ============================================================================
// Module      : y86_alu
// Description : Combinational Y86-64 ALU producing the result and {ZF,SF,OF}.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_alu
    import y86_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] i_alu_a,
    input  logic [DATA_W-1:0] i_alu_b,
    input  logic [3:0]        i_alu_fun,
    output logic [DATA_W-1:0] o_val_e,
    output logic [2:0]        o_flags
);

    logic [DATA_W-1:0] w_result;
    logic              w_of;
    logic              w_sa;
    logic              w_sb;
    logic              w_sr;

    always_comb begin
        w_result = '0;
        case (i_alu_fun)
            c_alu_add: w_result = i_alu_b + i_alu_a;
            c_alu_sub: w_result = i_alu_b - i_alu_a;
            c_alu_and: w_result = i_alu_b & i_alu_a;
            c_alu_xor: w_result = i_alu_b ^ i_alu_a;
            default:   w_result = '0;
        endcase
    end

    assign w_sa = i_alu_a[DATA_W-1];
    assign w_sb = i_alu_b[DATA_W-1];
    assign w_sr = w_result[DATA_W-1];

    // Signed overflow: the result sign disagrees with B when the operand signs make that impossible.
    always_comb begin
        w_of = 1'b0;
        case (i_alu_fun)
            c_alu_add: w_of = (w_sa == w_sb) && (w_sr != w_sb);
            c_alu_sub: w_of = (w_sa != w_sb) && (w_sr != w_sb);
            default:   w_of = 1'b0;
        endcase
    end

    assign o_val_e = w_result;
    assign o_flags = {(w_result == '0), w_sr, w_of};

endmodule
`default_nettype wire

// File: rtl/y86_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : y86_execute_stage
// Description : Y86-64 execute stage: operand select, ALU, CC register and M register.
// Revision    : 1.0 - initial release
// ============================================================================
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int         DATA_W = 64,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        E_stat,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [DATA_W-1:0] E_valC,
    input  logic [DATA_W-1:0] E_valA,
    input  logic [DATA_W-1:0] E_valB,
    input  logic [3:0]        E_dstE,
    input  logic [3:0]        E_dstM,
    input  logic [3:0]        m_stat,
    input  logic [3:0]        W_stat,
    input  logic              M_bubble,
    input  logic              M_stall,
    output logic [DATA_W-1:0] e_valE,
    output logic [3:0]        e_dstE,
    output logic              e_Cnd,
    output logic [3:0]        M_stat,
    output logic [3:0]        M_icode,
    output logic              M_Cnd,
    output logic [DATA_W-1:0] M_valE,
    output logic [DATA_W-1:0] M_valA,
    output logic [3:0]        M_dstE,
    output logic [3:0]        M_dstM,
    output logic [2:0]        cc
);

    localparam logic [DATA_W-1:0] c_pos8 = DATA_W'(8);
    localparam logic [DATA_W-1:0] c_neg8 = ~DATA_W'(7);

    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [3:0]        w_alu_fun;
    logic [2:0]        w_new_cc;
    logic              w_set_cc;
    logic [2:0]        r_cc;

    always_comb begin
        w_alu_a = '0;
        case (E_icode)
            c_icode_rrmovq, c_icode_opq:                     w_alu_a = E_valA;
            c_icode_irmovq, c_icode_rmmovq, c_icode_mrmovq: w_alu_a = E_valC;
            c_icode_call, c_icode_pushq:                     w_alu_a = c_neg8;
            c_icode_ret, c_icode_popq:                       w_alu_a = c_pos8;
            default:                                         w_alu_a = '0;
        endcase
    end

    always_comb begin
        w_alu_b = '0;
        case (E_icode)
            c_icode_rmmovq, c_icode_mrmovq, c_icode_opq, c_icode_call,
            c_icode_ret, c_icode_pushq, c_icode_popq:        w_alu_b = E_valB;
            default:                                         w_alu_b = '0;
        endcase
    end

    assign w_alu_fun = (E_icode == c_icode_opq) ? E_ifun : c_alu_add;

    y86_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_alu_a   (w_alu_a),
        .i_alu_b   (w_alu_b),
        .i_alu_fun (w_alu_fun),
        .o_val_e   (e_valE),
        .o_flags   (w_new_cc)
    );

    // An exception anywhere downstream freezes CC so later instructions cannot alter visible state.
    assign w_set_cc = (E_icode == c_icode_opq) && (E_stat == c_stat_aok) &&
                      (m_stat == c_stat_aok) && (W_stat == c_stat_aok);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cc <= 3'b100;
        end else if (w_set_cc) begin
            r_cc <= w_new_cc;
        end
    end

    assign cc = r_cc;

    assign e_Cnd  = ((E_icode == c_icode_rrmovq) || (E_icode == c_icode_jxx)) ?
                    cond_eval(E_ifun, r_cc) : 1'b1;
    assign e_dstE = ((E_icode == c_icode_rrmovq) && !e_Cnd) ? RNONE : E_dstE;

    always_ff @(posedge clk) begin
        if (reset || M_bubble) begin
            M_stat  <= c_bubble_stat;
            M_icode <= c_bubble_icode;
            M_Cnd   <= c_bubble_cnd;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE;
            M_dstM  <= RNONE;
        end else if (!M_stall) begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_y86_execute_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_y86_execute_stage
// Description : Directed plus randomized bench for the Y86-64 execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_execute_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  m_stat, W_stat;
    logic        M_bubble, M_stall;
    logic [63:0] e_valE;
    logic [3:0]  e_dstE;
    logic        e_Cnd;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic        M_Cnd;
    logic [63:0] M_valE, M_valA;
    logic [2:0]  cc;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [2:0]  x_cc;
    logic [3:0]  x_stat, x_icode, x_dstE, x_dstM;
    logic        x_cnd;
    logic [63:0] x_valE, x_valA;

    y86_execute_stage #(.DATA_W(64), .RNONE(4'hF)) dut (
        .clk(clk), .reset(reset),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat),
        .M_bubble(M_bubble), .M_stall(M_stall),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA),
        .M_dstE(M_dstE), .M_dstM(M_dstM), .cc(cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Instruction semantics in plain arithmetic; overflow from a 65-bit signed sum.
    task automatic ref_exec(input logic [3:0] icode, input logic [3:0] ifun,
                            input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                            output logic [63:0] r, output logic [2:0] fl);
        logic [63:0] a, b;
        logic [64:0] wide;
        logic        of;
        a = 64'd0; b = 64'd0; r = 64'd0; of = 1'b0; wide = 65'd0;
        case (icode)
            4'h2: a = va;
            4'h3: a = vc;
            4'h4: begin a = vc; b = vb; end
            4'h5: begin a = vc; b = vb; end
            4'h6: begin a = va; b = vb; end
            4'h8, 4'hA: begin a = 64'd0 - 64'd8; b = vb; end
            4'h9, 4'hB: begin a = 64'd8; b = vb; end
            default: ;
        endcase
        if (icode != 4'h6 || ifun == 4'h0) begin
            wide = {b[63], b} + {a[63], a};
            r = wide[63:0];
            of = wide[64] != wide[63];
        end else if (ifun == 4'h1) begin
            wide = {b[63], b} - {a[63], a};
            r = wide[63:0];
            of = wide[64] != wide[63];
        end else if (ifun == 4'h2) r = b & a;
        else if (ifun == 4'h3) r = b ^ a;
        fl = {r == 64'd0, $signed(r) < 0, of};
    endtask

    function automatic logic ref_cond(input logic [3:0] ifun, input logic [2:0] f);
        logic zf, less;
        zf = f[2];
        less = (f[1] != f[0]);
        case (ifun)
            4'd0: return 1'b1;
            4'd1: return less || zf;
            4'd2: return less;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !less;
            4'd6: return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic ref_bubble();
        x_stat = 4'h1; x_icode = 4'h1; x_cnd = 1'b0;
        x_valE = 64'd0; x_valA = 64'd0; x_dstE = 4'hF; x_dstM = 4'hF;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        logic [63:0] ve;
        logic [2:0]  fl;
        logic        cnd;
        logic [3:0]  de;
        #2;
        ref_exec(E_icode, E_ifun, E_valC, E_valA, E_valB, ve, fl);
        cnd = (E_icode == 4'h2 || E_icode == 4'h7) ? ref_cond(E_ifun, x_cc) : 1'b1;
        de  = (E_icode == 4'h2 && !cnd) ? 4'hF : E_dstE;
        if (!reset) begin
            check("e_valE", e_valE, ve);
            check("e_dstE", 64'(e_dstE), 64'(de));
            check("e_Cnd", 64'(e_Cnd), 64'(cnd));
        end
        if (reset) begin
            x_cc = 3'b100;
            ref_bubble();
        end else begin
            if (E_icode == 4'h6 && E_stat == 4'h1 && m_stat == 4'h1 && W_stat == 4'h1)
                x_cc = fl;
            if (M_bubble) ref_bubble();
            else if (!M_stall) begin
                x_stat = E_stat; x_icode = E_icode; x_cnd = cnd;
                x_valE = ve; x_valA = E_valA; x_dstE = de; x_dstM = E_dstM;
            end
        end
        @(posedge clk);
        #1;
        check("cc", 64'(cc), 64'(x_cc));
        check("M_stat", 64'(M_stat), 64'(x_stat));
        check("M_icode", 64'(M_icode), 64'(x_icode));
        check("M_Cnd", 64'(M_Cnd), 64'(x_cnd));
        check("M_valE", M_valE, x_valE);
        check("M_valA", M_valA, x_valA);
        check("M_dstE", 64'(M_dstE), 64'(x_dstE));
        check("M_dstM", 64'(M_dstM), 64'(x_dstM));
    endtask

    task automatic set_instr(input logic [3:0] icode, input logic [3:0] ifun,
                             input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                             input logic [3:0] de, input logic [3:0] dm);
        E_stat = 4'h1; E_icode = icode; E_ifun = ifun;
        E_valC = vc; E_valA = va; E_valB = vb; E_dstE = de; E_dstM = dm;
        m_stat = 4'h1; W_stat = 4'h1; M_bubble = 1'b0; M_stall = 1'b0; reset = 1'b0;
    endtask

    function automatic logic [63:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'(int'($urandom_range(0, 15)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        x_cc = 3'b100;
        ref_bubble();
        // Reset with garbage on the inputs
        set_instr(4'h6, 4'h0, 64'h1234, 64'hDEAD, 64'hBEEF, 4'h2, 4'h3);
        reset = 1'b1;
        cycle();
        cycle();
        set_instr(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF);
        cycle();
        check("reset_cc", 64'(cc), 64'h4);
        check("reset_M_icode", 64'(M_icode), 64'h1);

        // Signed overflow on add
        set_instr(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h2, 4'hF);
        cycle();
        check("add_ovf_cc", 64'(cc), 64'h3);
        check("add_ovf_M_valE", M_valE, 64'h8000_0000_0000_0000);

        // Equal subtract then branches on the result
        set_instr(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h2, 4'hF);
        cycle();
        check("sub_eq_cc", 64'(cc), 64'h4);
        set_instr(4'h7, 4'h1, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        cycle();
        set_instr(4'h7, 4'h6, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF);
        #2 check("jg_not_taken", 64'(e_Cnd), 64'h0);
        cycle();

        // Conditional move suppressed, then unconditional move
        set_instr(4'h2, 4'h4, 64'd0, 64'h55, 64'd0, 4'h3, 4'hF);
        cycle();
        check("cmovne_M_dstE", 64'(M_dstE), 64'hF);
        set_instr(4'h2, 4'h0, 64'd0, 64'h55, 64'd0, 4'h3, 4'hF);
        cycle();

        // Stack and address arithmetic leave CC alone
        set_instr(4'hA, 4'h0, 64'd0, 64'h9, 64'h100, 4'h4, 4'hF);
        cycle();
        check("push_M_valE", M_valE, 64'hF8);
        set_instr(4'hB, 4'h0, 64'd0, 64'h0, 64'hF8, 4'h4, 4'h5);
        cycle();
        set_instr(4'h5, 4'h0, 64'h10, 64'h0, 64'h20, 4'hF, 4'h6);
        cycle();
        check("mrmov_cc_hold", 64'(cc), 64'h4);

        // Downstream exception blocks the CC update
        set_instr(4'h6, 4'h0, 64'd0, 64'd1, 64'd2, 4'h2, 4'hF);
        m_stat = 4'h3;
        cycle();
        check("adr_cc_hold", 64'(cc), 64'h4);

        // Stall holds M for two cycles
        set_instr(4'h6, 4'h3, 64'd0, 64'hF0, 64'h0F, 4'h7, 4'hF);
        M_stall = 1'b1;
        cycle();
        set_instr(4'h3, 4'h0, 64'h77, 64'd0, 64'd0, 4'h1, 4'hF);
        M_stall = 1'b1;
        cycle();

        // Bubble wins over stall
        set_instr(4'h3, 4'h0, 64'h77, 64'd0, 64'd0, 4'h1, 4'hF);
        M_stall = 1'b1;
        M_bubble = 1'b1;
        cycle();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_instr(4'($urandom_range(0, 11)),
                      ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6)),
                      rand_word(), rand_word(), rand_word(),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 9) == 0) E_stat = 4'($urandom_range(1, 4));
            if ($urandom_range(0, 9) == 0) m_stat = 4'($urandom_range(1, 4));
            if ($urandom_range(0, 9) == 0) W_stat = 4'($urandom_range(1, 4));
            M_stall  = ($urandom_range(0, 7) == 0);
            M_bubble = ($urandom_range(0, 9) == 0);
            reset    = ($urandom_range(0, 39) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
